serial_pair_serializer: RTL and testbench

//   Parallel-to-serial transmitter for operand pairs feeding the serial comparators.
//   - Accepts two W-bit operands (a, b) over a valid/ready handshake.
//   - Emits them one bit pair per beat, MSB-first or LSB-first, with first/last frame markers.
//   - Sits upstream of serial_comparator_* so parallel test vectors or datapath values
//     can drive the bit-serial compare chain.
//

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_shift_reg.sv | 39 +++
 rtl/serial_pair_serializer.sv | 120 ++++++++++++
 tb/tb_serial_pair_serializer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial operand path.
// Holds the serializer FSM encoding and default operand width.
package serial_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

  localparam int SER_DEFAULT_W = 16;

endpackage

// File: rtl/serial_shift_reg.sv
// One operand lane of the pair serializer.
// Parallel load, single-step shift toward the tap, otherwise hold.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int W         = SER_DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         tap_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = d_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap_o = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial transmitter for (a, b) operand pairs.
// Define SERIAL_PAIR_SERIALIZER_B2B_EN to allow reload on the last beat.
module serial_pair_serializer
  import serial_pkg::*;
#(
  parameter int W         = SER_DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_a,
  output logic         out_b,
  output logic         out_first,
  output logic         out_last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          first_q;
  logic          last_q;

  logic accept;
  logic beat;
  logic shift;

`ifdef SERIAL_PAIR_SERIALIZER_B2B_EN
  assign in_ready = rst & ((state_q == SER_IDLE) |
                           ((state_q == SER_SEND) & last_q & out_ready));
`else
  assign in_ready = rst & (state_q == SER_IDLE);
`endif

  assign accept = in_valid & in_ready;
  assign beat   = valid_q & out_ready;
  assign shift  = beat & ~last_q;

  serial_shift_reg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i (shift),
    .d_i     (in_a),
    .tap_o   (out_a)
  );

  serial_shift_reg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i (shift),
    .d_i     (in_b),
    .tap_o   (out_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        SER_IDLE: begin
          if (accept) begin
            state_q <= SER_SEND;
            cnt_q   <= CNT_INIT;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (W == 1);
          end
        end
        SER_SEND: begin
          if (beat) begin
            if (last_q) begin
              // Reload only reachable when last-beat accept is enabled
              if (accept) begin
                cnt_q   <= CNT_INIT;
                first_q <= 1'b1;
                last_q  <= (W == 1);
              end else begin
                state_q <= SER_IDLE;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              cnt_q   <= cnt_q - CNT_ONE;
              first_q <= 1'b0;
              last_q  <= (cnt_q == CNT_ONE);
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Randomized self-checking bench for serial_pair_serializer.
// Streams are predicted from operand values by bit index.
module tb_serial_pair_serializer;

  logic clk;
  logic rst;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [15:0] m_in_a, m_in_b;
  logic        m_out_a, m_out_b, m_out_first, m_out_last;

  logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic [15:0] l_in_a, l_in_b;
  logic        l_out_a, l_out_b, l_out_first, l_out_last;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [0:0]  s_in_a, s_in_b;
  logic        s_out_a, s_out_b, s_out_first, s_out_last;

  int n_cmp;
  int n_err;

`ifdef SERIAL_PAIR_SERIALIZER_B2B_EN
  localparam int EXP_GAPS = 0;
`else
  localparam int EXP_GAPS = 1;
`endif

  serial_pair_serializer #(.W(16), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_a(m_out_a), .out_b(m_out_b),
    .out_first(m_out_first), .out_last(m_out_last)
  );

  serial_pair_serializer #(.W(16), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b),
    .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_a(l_out_a), .out_b(l_out_b),
    .out_first(l_out_first), .out_last(l_out_last)
  );

  serial_pair_serializer #(.W(1), .MSB_FIRST(1'b1)) u_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_a(s_out_a), .out_b(s_out_b),
    .out_first(s_out_first), .out_last(s_out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit sent on beat k of a 16-bit frame
  function automatic logic bit_of(input logic [15:0] v, input int k,
                                  input bit msb);
    return msb ? v[15-k] : v[k];
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    m_in_valid = 0; m_out_ready = 1; m_in_a = '0; m_in_b = '0;
    l_in_valid = 0; l_out_ready = 1; l_in_a = '0; l_in_b = '0;
    s_in_valid = 0; s_out_ready = 1; s_in_a = '0; s_in_b = '0;
    #3;
    n_cmp++;
    if ({m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs got=%b exp=00000",
               {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last});
    end
    n_cmp++;
    if ({m_in_ready, l_in_ready, s_in_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_in_ready got=%b exp=000",
               {m_in_ready, l_in_ready, s_in_ready});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_in_ready, l_in_ready, s_in_ready, m_out_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_release got=%b exp=1110",
               {m_in_ready, l_in_ready, s_in_ready, m_out_valid});
    end
  endtask

  task automatic test_msb_stream;
    logic [15:0] a, b;
    logic [4:0]  got, exp;
    for (int p = 0; p < 5; p++) begin
      if (p == 0) begin
        a = 16'b0110_0100_1000_0010;
        b = 16'b0110_0010_0110_0010;
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      n_cmp++;
      if (m_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL msb_idle_ready got=%b exp=1", m_in_ready);
      end
      m_in_a = a; m_in_b = b; m_in_valid = 1; m_out_ready = 1;
      @(negedge clk);
      m_in_valid = 0;
      for (int k = 0; k < 16; k++) begin
        exp = {1'b1, bit_of(a, k, 1), bit_of(b, k, 1), k == 0, k == 15};
        got = {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL msb_beat%0d got=%b exp=%b", k, got, exp);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (m_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL msb_end_valid got=%b exp=0", m_out_valid);
      end
    end
  endtask

  task automatic test_lsb_stream;
    logic [15:0] a, b;
    logic [4:0]  got, exp;
    for (int p = 0; p < 4; p++) begin
      if (p == 0) begin
        a = 16'b0110_0100_1000_0010;
        b = 16'b0110_0010_0110_0010;
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      l_in_a = a; l_in_b = b; l_in_valid = 1;
      @(negedge clk);
      l_in_valid = 0;
      for (int k = 0; k < 16; k++) begin
        exp = {1'b1, bit_of(a, k, 0), bit_of(b, k, 0), k == 0, k == 15};
        got = {l_out_valid, l_out_a, l_out_b, l_out_first, l_out_last};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL lsb_beat%0d got=%b exp=%b", k, got, exp);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (l_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL lsb_end_valid got=%b exp=0", l_out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] a, b;
    logic [4:0]  got, exp;
    logic        rdy;
    int          k, stall, cyc;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        a = 16'b0110_0100_1000_0010;
        b = 16'b0110_0010_0110_0010;
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      m_in_a = a; m_in_b = b; m_in_valid = 1; m_out_ready = 1;
      @(negedge clk);
      m_in_valid = 0;
      k = 0; stall = 0; cyc = 0;
      while (k < 16 && cyc < 100) begin
        exp = {1'b1, bit_of(a, k, 1), bit_of(b, k, 1), k == 0, k == 15};
        got = {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL bp_beat%0d got=%b exp=%b", k, got, exp);
        end
        if (p == 0) rdy = !(k == 3 && stall < 3);
        else rdy = ($urandom_range(0, 2) != 0);
        if (!rdy) stall++;
        m_out_ready = rdy;
        @(posedge clk);
        if (rdy) k++;
        @(negedge clk);
        cyc++;
      end
      m_out_ready = 1;
      n_cmp++;
      if (k !== 16) begin
        n_err++;
        $display("FAIL bp_timeout got=%0d exp=16", k);
      end
      n_cmp++;
      if (m_out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_end_valid got=%b exp=0", m_out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] aa [2];
    logic [15:0] bb [2];
    logic [4:0]  got, exp;
    logic        acc;
    int          idx, gaps, np, k, f;
    aa[0] = 16'($urandom); bb[0] = 16'($urandom);
    aa[1] = 16'($urandom); bb[1] = 16'($urandom);
    @(negedge clk);
    m_in_a = aa[0]; m_in_b = bb[0]; m_in_valid = 1; m_out_ready = 1;
    idx = 0; gaps = 0; np = 0;
    for (int c = 0; c < 60 && idx < 32; c++) begin
      if (m_out_valid) begin
        f = idx / 16; k = idx % 16;
        exp = {1'b1, bit_of(aa[f], k, 1), bit_of(bb[f], k, 1), k == 0, k == 15};
        got = {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL b2b_beat%0d got=%b exp=%b", idx, got, exp);
        end
        idx++;
      end else if (idx > 0) begin
        gaps++;
      end
      acc = m_in_valid & m_in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        np++;
        if (np == 1) begin
          m_in_a = aa[1]; m_in_b = bb[1];
        end else begin
          m_in_valid = 0;
        end
      end
    end
    m_in_valid = 0;
    n_cmp++;
    if (idx !== 32) begin
      n_err++;
      $display("FAIL b2b_beats got=%0d exp=32", idx);
    end
    n_cmp++;
    if (gaps !== EXP_GAPS) begin
      n_err++;
      $display("FAIL b2b_gaps got=%0d exp=%0d", gaps, EXP_GAPS);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [15:0] a, b;
    logic [4:0]  got, exp;
    a = 16'($urandom); b = 16'($urandom);
    @(negedge clk);
    m_in_a = a; m_in_b = b; m_in_valid = 1; m_out_ready = 1;
    @(negedge clk);
    m_in_valid = 0;
    repeat (7) @(negedge clk);
    exp = {1'b1, bit_of(a, 7, 1), bit_of(b, 7, 1), 1'b0, 1'b0};
    got = {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rst_beat7 got=%b exp=%b", got, exp);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_out_valid, m_in_ready, m_out_last} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_async_drop got=%b exp=000",
               {m_out_valid, m_in_ready, m_out_last});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_in_ready, m_out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_idle_after got=%b exp=10", {m_in_ready, m_out_valid});
    end
    a = 16'($urandom); b = 16'($urandom);
    @(negedge clk);
    m_in_a = a; m_in_b = b; m_in_valid = 1;
    @(negedge clk);
    m_in_valid = 0;
    exp = {1'b1, bit_of(a, 0, 1), bit_of(b, 0, 1), 1'b1, 1'b0};
    got = {m_out_valid, m_out_a, m_out_b, m_out_first, m_out_last};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rst_restart got=%b exp=%b", got, exp);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_w1;
    logic [2:0] va, vb;
    logic [4:0] got, exp;
    va = 3'b101; vb = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_in_a = va[i]; s_in_b = vb[i]; s_in_valid = 1;
      @(negedge clk);
      s_in_valid = 0;
      exp = {1'b1, va[i], vb[i], 1'b1, 1'b1};
      got = {s_out_valid, s_out_a, s_out_b, s_out_first, s_out_last};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL w1_beat%0d got=%b exp=%b", i, got, exp);
      end
      @(negedge clk);
      n_cmp++;
      if ({s_out_valid, s_in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL w1_idle%0d got=%b exp=01", i, {s_out_valid, s_in_ready});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_msb_stream();
    test_lsb_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
